// File: rtl/controle_multiciclo.sv
// Multicycle control unit: fetch/decode/execute/memory/writeback sequencer
// with memory wait states, stall freeze and an illegal-opcode trap.
module controle_multiciclo #(
   parameter int ALU_OP_W = 3,
   parameter int MEM_WAIT = 1
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                STALL,
   input  logic [6:0]          OPCODE,
   input  logic                ZERO,
   output logic                reset_wire,
   output logic [ALU_OP_W-1:0] operacao,
   output logic                WRITE_PC,
   output logic                PC_SRC,
   output logic                WRITE_INSTRUCTION,
   output logic                WR_MEM_INSTR,
   output logic                ALU_SRC_B,
   output logic                REG_WRITE,
   output logic                MEM_READ,
   output logic                MEM_WRITE,
   output logic                MEM_TO_REG,
   output logic                TRAP,
   output logic [3:0]          STATE
);

   typedef enum logic [3:0] {
      S_RESET      = 4'd0,
      S_FETCH_WAIT = 4'd1,
      S_FETCH_IR   = 4'd2,
      S_DECODE     = 4'd3,
      S_EXEC       = 4'd4,
      S_MEM_RD     = 4'd5,
      S_MEM_WR     = 4'd6,
      S_WRITEBACK  = 4'd7,
      S_PC_INC     = 4'd8,
      S_HALT_TRAP  = 4'd9
   } state_t;

   typedef enum logic [2:0] {
      C_NONE  = 3'd0,
      C_R     = 3'd1,
      C_I     = 3'd2,
      C_LOAD  = 3'd3,
      C_STORE = 3'd4,
      C_BEQ   = 3'd5
   } cls_t;

   localparam logic [3:0] WAIT_LD = 4'(MEM_WAIT);

   state_t     state;
   cls_t       cls;
   cls_t       dec_cls;
   logic [3:0] wait_cnt;
   logic       frozen;
   logic [2:0] op3;

   always_comb begin
      dec_cls = C_NONE;
      unique case (OPCODE)
         7'b0110011: dec_cls = C_R;
         7'b0010011: dec_cls = C_I;
         7'b0000011: dec_cls = C_LOAD;
         7'b0100011: dec_cls = C_STORE;
         7'b1100011: dec_cls = C_BEQ;
         default:    dec_cls = C_NONE;
      endcase
   end

   // RESET and HALT_TRAP do not honour STALL
   assign frozen = STALL && (state != S_RESET) && (state != S_HALT_TRAP);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= S_RESET;
         cls      <= C_NONE;
         wait_cnt <= '0;
      end else if (!frozen) begin
         unique case (state)
            S_RESET: begin
               state    <= S_FETCH_WAIT;
               wait_cnt <= WAIT_LD;
            end
            S_FETCH_WAIT: begin
               if (wait_cnt == 4'd0) state <= S_FETCH_IR;
               else                  wait_cnt <= wait_cnt - 4'd1;
            end
            S_FETCH_IR: state <= S_DECODE;
            S_DECODE: begin
               cls   <= dec_cls;
               state <= (dec_cls == C_NONE) ? S_HALT_TRAP : S_EXEC;
            end
            S_EXEC: begin
               unique case (cls)
                  C_R, C_I: state <= S_WRITEBACK;
                  C_LOAD: begin
                     state    <= S_MEM_RD;
                     wait_cnt <= WAIT_LD;
                  end
                  C_STORE: state <= S_MEM_WR;
                  C_BEQ:   state <= S_PC_INC;
                  default: state <= S_HALT_TRAP;
               endcase
            end
            S_MEM_RD: begin
               if (wait_cnt == 4'd0) state <= S_WRITEBACK;
               else                  wait_cnt <= wait_cnt - 4'd1;
            end
            S_MEM_WR:    state <= S_PC_INC;
            S_WRITEBACK: state <= S_PC_INC;
            S_PC_INC: begin
               state    <= S_FETCH_WAIT;
               wait_cnt <= WAIT_LD;
            end
            S_HALT_TRAP: state <= S_HALT_TRAP;
            default:     state <= S_RESET;
         endcase
      end
   end

   always_comb begin
      op3               = 3'b000;
      reset_wire        = 1'b0;
      WRITE_PC          = 1'b0;
      PC_SRC            = 1'b0;
      WRITE_INSTRUCTION = 1'b0;
      WR_MEM_INSTR      = 1'b0;
      ALU_SRC_B         = 1'b0;
      REG_WRITE         = 1'b0;
      MEM_READ          = 1'b0;
      MEM_WRITE         = 1'b0;
      MEM_TO_REG        = 1'b0;
      TRAP              = 1'b0;
      unique case (state)
         S_RESET: begin
            reset_wire   = 1'b1;
            WR_MEM_INSTR = 1'b1;
         end
         S_FETCH_WAIT: WR_MEM_INSTR = 1'b1;
         S_FETCH_IR: begin
            WR_MEM_INSTR      = 1'b1;
            WRITE_INSTRUCTION = !frozen;
         end
         S_DECODE: WR_MEM_INSTR = 1'b1;
         S_EXEC: begin
            unique case (cls)
               C_R: op3 = 3'b011;
               C_I: begin
                  op3       = 3'b011;
                  ALU_SRC_B = 1'b1;
               end
               C_LOAD, C_STORE: begin
                  op3       = 3'b001;
                  ALU_SRC_B = 1'b1;
               end
               C_BEQ:   op3 = 3'b010;
               default: op3 = 3'b000;
            endcase
         end
         S_MEM_RD: MEM_READ = 1'b1;
         S_MEM_WR: MEM_WRITE = !frozen;
         S_WRITEBACK: begin
            REG_WRITE  = !frozen;
            MEM_TO_REG = (cls == C_LOAD);
         end
         S_PC_INC: begin
            op3      = 3'b001;
            WRITE_PC = !frozen;
            PC_SRC   = (cls == C_BEQ) && ZERO;
         end
         S_HALT_TRAP: begin
            TRAP         = 1'b1;
            WR_MEM_INSTR = 1'b1;
         end
         default: reset_wire = 1'b1;
      endcase
   end

   always_comb begin
      operacao      = '0;
      operacao[2:0] = op3;
   end

   assign STATE = state;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: cycle vector table at MEM_WAIT=1
// plus hand sequences for wait states and async reset at MEM_WAIT=2.
module tb_controle_multiciclo;

   localparam logic [3:0] S_RST = 4'd0, S_FW = 4'd1, S_IR = 4'd2;
   localparam logic [3:0] S_DEC = 4'd3, S_EX = 4'd4, S_MR = 4'd5;
   localparam logic [3:0] S_MW = 4'd6, S_WB = 4'd7, S_PC = 4'd8;
   localparam logic [3:0] S_HT = 4'd9;

   localparam logic [6:0] OR = 7'b0110011, OI = 7'b0010011;
   localparam logic [6:0] OL = 7'b0000011, OS = 7'b0100011;
   localparam logic [6:0] OB = 7'b1100011, OX = 7'b1111111;

   // {rw, op[2:0], wpc, pcsrc, wi, wmi, asb, rgw, mr, mw, m2r, trap}
   localparam logic [13:0] O_RST = 14'b1_000_0_0_0_1_0_0_0_0_0_0;
   localparam logic [13:0] O_WMI = 14'b0_000_0_0_0_1_0_0_0_0_0_0;
   localparam logic [13:0] O_IR  = 14'b0_000_0_0_1_1_0_0_0_0_0_0;
   localparam logic [13:0] O_XR  = 14'b0_011_0_0_0_0_0_0_0_0_0_0;
   localparam logic [13:0] O_XI  = 14'b0_011_0_0_0_0_1_0_0_0_0_0;
   localparam logic [13:0] O_XM  = 14'b0_001_0_0_0_0_1_0_0_0_0_0;
   localparam logic [13:0] O_XB  = 14'b0_010_0_0_0_0_0_0_0_0_0_0;
   localparam logic [13:0] O_MR  = 14'b0_000_0_0_0_0_0_0_1_0_0_0;
   localparam logic [13:0] O_MW  = 14'b0_000_0_0_0_0_0_0_0_1_0_0;
   localparam logic [13:0] O_WB  = 14'b0_000_0_0_0_0_0_1_0_0_0_0;
   localparam logic [13:0] O_WBL = 14'b0_000_0_0_0_0_0_1_0_0_1_0;
   localparam logic [13:0] O_PC  = 14'b0_001_1_0_0_0_0_0_0_0_0_0;
   localparam logic [13:0] O_PCT = 14'b0_001_1_1_0_0_0_0_0_0_0_0;
   localparam logic [13:0] O_PCS = 14'b0_001_0_1_0_0_0_0_0_0_0_0;
   localparam logic [13:0] O_TRP = 14'b0_000_0_0_0_1_0_0_0_0_0_1;
   localparam logic [13:0] O_NON = 14'b0_000_0_0_0_0_0_0_0_0_0_0;

   typedef struct {
      logic        stall;
      logic [6:0]  opc;
      logic        zero;
      logic [3:0]  st;
      logic [13:0] o;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst1 = 1'b0, rst2 = 1'b0;
   logic       stall = 1'b0, zero = 1'b0;
   logic [6:0] opc1 = 7'b0110011, opc2 = 7'b0000011;

   logic       rw1, wpc1, pcs1, wi1, wmi1, asb1, rgw1, mr1, mw1, m2r1, trp1;
   logic [3:0] op1, st1;
   logic       rw2, wpc2, pcs2, wi2, wmi2, asb2, rgw2, mr2, mw2, m2r2, trp2;
   logic [2:0] op2;
   logic [3:0] st2;

   controle_multiciclo #(.ALU_OP_W(4), .MEM_WAIT(1)) dut1 (
      .CLK(clk), .RST_N(rst1), .STALL(stall), .OPCODE(opc1),
      .ZERO(zero), .reset_wire(rw1), .operacao(op1),
      .WRITE_PC(wpc1), .PC_SRC(pcs1), .WRITE_INSTRUCTION(wi1),
      .WR_MEM_INSTR(wmi1), .ALU_SRC_B(asb1), .REG_WRITE(rgw1),
      .MEM_READ(mr1), .MEM_WRITE(mw1), .MEM_TO_REG(m2r1),
      .TRAP(trp1), .STATE(st1)
   );

   controle_multiciclo #(.ALU_OP_W(3), .MEM_WAIT(2)) dut2 (
      .CLK(clk), .RST_N(rst2), .STALL(stall), .OPCODE(opc2),
      .ZERO(zero), .reset_wire(rw2), .operacao(op2),
      .WRITE_PC(wpc2), .PC_SRC(pcs2), .WRITE_INSTRUCTION(wi2),
      .WR_MEM_INSTR(wmi2), .ALU_SRC_B(asb2), .REG_WRITE(rgw2),
      .MEM_READ(mr2), .MEM_WRITE(mw2), .MEM_TO_REG(m2r2),
      .TRAP(trp2), .STATE(st2)
   );

   logic [14:0] act1;
   assign act1 = {rw1, op1, wpc1, pcs1, wi1, wmi1, asb1,
                  rgw1, mr1, mw1, m2r1, trp1};

   int pass_n = 0;
   int total_n = 0;
   vec_t tv[$];

   task automatic chk(input string nm, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      total_n++;
      if (act === exp) pass_n++;
      else $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
   endtask

   task automatic add(input logic s, input logic [6:0] o, input logic z,
                      input logic [3:0] st, input logic [13:0] ob);
      vec_t v;
      v.stall = s; v.opc = o; v.zero = z; v.st = st; v.o = ob;
      tv.push_back(v);
   endtask

   task automatic chk_out1(input string nm, input int idx,
                           input logic [3:0] st, input logic [13:0] ob);
      chk({nm, "_state"}, idx, 32'(st1), 32'(st));
      chk({nm, "_outs"}, idx, 32'(act1), 32'({ob[13], 1'b0, ob[12:0]}));
   endtask

   initial begin
      int cyc, mr_cnt, fw_cnt;
      // R-type, opcode garbage outside DECODE, ZERO=1 must not redirect PC
      add(0,OX,0,S_FW,O_WMI); add(0,OX,0,S_FW,O_WMI);
      add(0,OX,0,S_IR,O_IR);  add(0,OR,0,S_DEC,O_WMI);
      add(0,OX,1,S_EX,O_XR);  add(0,OX,1,S_WB,O_WB);
      add(0,OX,1,S_PC,O_PC);
      // I-ALU
      add(0,OX,0,S_FW,O_WMI); add(0,OX,0,S_FW,O_WMI);
      add(0,OX,0,S_IR,O_IR);  add(0,OI,0,S_DEC,O_WMI);
      add(0,OX,0,S_EX,O_XI);  add(0,OX,0,S_WB,O_WB);
      add(0,OX,0,S_PC,O_PC);
      // LOAD at MEM_WAIT=1: two MEM_RD cycles
      add(0,OX,0,S_FW,O_WMI); add(0,OX,0,S_FW,O_WMI);
      add(0,OX,0,S_IR,O_IR);  add(0,OL,0,S_DEC,O_WMI);
      add(0,OX,0,S_EX,O_XM);  add(0,OX,0,S_MR,O_MR);
      add(0,OX,0,S_MR,O_MR);  add(0,OX,0,S_WB,O_WBL);
      add(0,OX,0,S_PC,O_PC);
      // STORE with one stalled MEM_WR cycle
      add(0,OX,0,S_FW,O_WMI); add(0,OX,0,S_FW,O_WMI);
      add(0,OX,0,S_IR,O_IR);  add(0,OS,0,S_DEC,O_WMI);
      add(0,OX,0,S_EX,O_XM);  add(1,OX,0,S_MW,O_NON);
      add(0,OX,0,S_MW,O_MW);  add(0,OX,0,S_PC,O_PC);
      // BEQ taken, stalled once in PC_INC
      add(0,OX,0,S_FW,O_WMI); add(0,OX,0,S_FW,O_WMI);
      add(0,OX,0,S_IR,O_IR);  add(0,OB,0,S_DEC,O_WMI);
      add(0,OX,1,S_EX,O_XB);  add(1,OX,1,S_PC,O_PCS);
      add(0,OX,1,S_PC,O_PCT);
      // BEQ not taken
      add(0,OX,0,S_FW,O_WMI); add(0,OX,0,S_FW,O_WMI);
      add(0,OX,0,S_IR,O_IR);  add(0,OB,0,S_DEC,O_WMI);
      add(0,OX,0,S_EX,O_XB);  add(0,OX,0,S_PC,O_PC);
      // R-type with stalls in FETCH_WAIT, DECODE and 3 cycles in WRITEBACK
      add(1,OX,0,S_FW,O_WMI); add(0,OX,0,S_FW,O_WMI);
      add(0,OX,0,S_FW,O_WMI); add(0,OX,0,S_IR,O_IR);
      add(1,OX,0,S_DEC,O_WMI); add(0,OR,0,S_DEC,O_WMI);
      add(0,OX,0,S_EX,O_XR);  add(1,OX,0,S_WB,O_NON);
      add(1,OX,0,S_WB,O_NON); add(1,OX,0,S_WB,O_NON);
      add(0,OX,0,S_WB,O_WB);  add(0,OX,0,S_PC,O_PC);
      // Illegal opcode, then STALL and legal opcodes must not leave the trap
      add(0,OR,0,S_FW,O_WMI); add(0,OR,0,S_FW,O_WMI);
      add(0,OR,0,S_IR,O_IR);  add(0,OX,0,S_DEC,O_WMI);
      add(1,OR,0,S_HT,O_TRP); add(1,OR,0,S_HT,O_TRP);
      add(0,OB,1,S_HT,O_TRP); add(0,OL,0,S_HT,O_TRP);

      // reset state, then release cycle with STALL high (ignored in RESET)
      repeat (2) @(posedge clk);
      #1 chk_out1("reset", 0, S_RST, O_RST);
      stall = 1'b1;
      rst1  = 1'b1;
      #1 chk_out1("release", 0, S_RST, O_RST);

      foreach (tv[i]) begin
         @(posedge clk);
         #1;
         stall = tv[i].stall;
         opc1  = tv[i].opc;
         zero  = tv[i].zero;
         #1 chk_out1("vec", i, tv[i].st, tv[i].o);
      end

      // asynchronous reset out of HALT_TRAP, mid-cycle
      #2 rst1 = 1'b0;
      #1;
      chk("trap_rst_state", 0, 32'(st1), 32'(S_RST));
      chk("trap_rst_trap", 0, 32'(trp1), 32'd0);
      chk("trap_rst_rw", 0, 32'(rw1), 32'd1);

      // LOAD at MEM_WAIT=2: 2W+7 = 11 cycles, MEM_READ for W+1 = 3
      stall = 1'b0;
      zero  = 1'b0;
      opc2  = OL;
      @(posedge clk);
      #1 rst2 = 1'b1;
      cyc = 0;
      mr_cnt = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (mr2) mr_cnt++;
         if (st2 == S_WB) begin
            chk("load_wb_m2r", c, 32'(m2r2), 32'd1);
            chk("load_wb_rgw", c, 32'(rgw2), 32'd1);
         end
         if (st2 == S_PC) begin
            cyc = c;
            break;
         end
      end
      chk("load_cycles", 0, 32'(cyc), 32'd11);
      chk("load_mr_cycles", 0, 32'(mr_cnt), 32'd3);

      // second LOAD: reset dropped inside MEM_RD
      cyc = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (st2 == S_MR) begin
            cyc = c;
            break;
         end
      end
      chk("reach_mem_rd", 0, 32'(cyc != 0), 32'd1);
      #2 rst2 = 1'b0;
      #1;
      chk("mid_rst_state", 0, 32'(st2), 32'(S_RST));
      chk("mid_rst_mr", 0, 32'(mr2), 32'd0);
      chk("mid_rst_rw", 0, 32'(rw2), 32'd1);

      // fresh wait count after reset: FETCH_WAIT lasts W+1 = 3 cycles
      @(posedge clk);
      #1 rst2 = 1'b1;
      opc2 = OR;
      fw_cnt = 0;
      cyc = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (st2 == S_FW) fw_cnt++;
         if (st2 == S_IR) begin
            cyc = c;
            break;
         end
      end
      chk("fresh_fw_cycles", 0, 32'(fw_cnt), 32'd3);
      chk("fresh_ir_at", 0, 32'(cyc), 32'd4);

      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end

endmodule
